seven_segment_scanner: RTL

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode/cathode seven-segment display bank. It holds a packed multi-digit BCD value and scans one digit at a time at a programmable refresh rate. New values are double-buffered so they take effect only at frame boundaries. It sits between the numeric datapath (counters, measurement blocks) and the board display pins, and supersedes the single-digit combinational decoder.

---
 rtl/seven_segment_scanner.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//   Time-multiplexed driver for a DIGITS-wide seven-segment display bank.
//   It holds a packed BCD value and lights one digit at a time. Each digit stays
//   lit for REFRESH_DIV clocks. New values are double-buffered (pending ->
//   active) and take effect only at frame boundaries.
//
//   Optional build macro: HEX_DIGITS_EN. When it is defined, codes 10..15 show
//   the glyphs A b C d E F. When it is undefined, those codes blank the digit.
//
//   Parameters
//     DIGITS       number of digits scanned (1..8)
//     REFRESH_DIV  clk cycles each digit stays lit (>= 1)
//     ACTIVE_LOW   1 inverts seg/dp/an at the output register
//
//   Ports
//     clk     in   system clock, rising edge
//     rst_n   in   asynchronous active-low reset
//     load    in   strobe; captures value/dp_in into the pending buffer
//     value   in   packed digit codes, digit k = value[4k+3:4k], digit 0 rightmost
//     dp_in   in   decimal point per digit
//     blank   in   level; forces every digit off
//     lzs     in   level; enables leading-zero suppression
//     seg     out  segments a..g on seg[6]..seg[0]
//     dp      out  decimal point of the lit digit
//     an      out  one-hot digit enable
//     frame   out  one-cycle pulse when the scan wraps back to digit 0
// -----------------------------------------------------------------------------

// Per-digit glyph decoder. Every digit is decoded in parallel; the top level
// then selects the scanned digit.
module seven_segment_lane (
    input  logic [3:0] code,
    input  logic       suppress,  // leading zero to be hidden
    output logic [6:0] seg
);
    logic [6:0] glyph;

    always_comb begin
        case (code)
            4'd0:    glyph = 7'h7E;
            4'd1:    glyph = 7'h30;
            4'd2:    glyph = 7'h6D;
            4'd3:    glyph = 7'h79;
            4'd4:    glyph = 7'h33;
            4'd5:    glyph = 7'h5B;
            4'd6:    glyph = 7'h5F;
            4'd7:    glyph = 7'h70;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h7B;
`ifdef HEX_DIGITS_EN
            4'd10:   glyph = 7'h77;
            4'd11:   glyph = 7'h1F;
            4'd12:   glyph = 7'h4E;
            4'd13:   glyph = 7'h3D;
            4'd14:   glyph = 7'h4F;
            4'd15:   glyph = 7'h47;
`endif
            default: glyph = 7'h00;
        endcase
    end

    assign seg = suppress ? 7'h00 : glyph;
endmodule

module seven_segment_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank,
    input  logic                  lzs,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);
    localparam int             PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]  IMAX = IW'(DIGITS - 1);
    localparam logic           POL  = (ACTIVE_LOW != 0);

    logic [PW-1:0]            pcnt;
    logic [IW-1:0]            idx;
    logic                     tick;
    logic                     boundary;

    logic [DIGITS-1:0][3:0]   pend_val;
    logic [DIGITS-1:0]        pend_dp;
    logic                     pend_v;
    logic [DIGITS-1:0][3:0]   act_val;
    logic [DIGITS-1:0]        act_dp;

    logic [DIGITS-1:0]        supp;
    logic [DIGITS-1:0][6:0]   lane_seg;

    logic [6:0]               seg_n;
    logic                     dp_n;
    logic [DIGITS-1:0]        an_n;

    assign tick     = (pcnt == PMAX);
    assign boundary = tick && (idx == IMAX);

    // Prescaler and scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick)
                idx <= (idx == IMAX) ? '0 : idx + 1'b1;
        end
    end

    // Double buffer. A load on the boundary cycle goes straight into active,
    // so it wins over any older pending value and leaves nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend_v   <= 1'b0;
            act_val  <= '0;
            act_dp   <= '0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            if (boundary) begin
                if (load) begin
                    act_val <= value;
                    act_dp  <= dp_in;
                end else if (pend_v) begin
                    act_val <= pend_val;
                    act_dp  <= pend_dp;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pend_v <= 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every higher digit are code 0.
    // Digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        supp       = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (act_val[k] == 4'd0);
            supp[k]    = lzs && (k != 0) && upper_zero;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_lane
            seven_segment_lane u_lane (
                .code     (act_val[g]),
                .suppress (supp[g]),
                .seg      (lane_seg[g])
            );
        end
    endgenerate

    // Select the scanned digit. Blank masks only the outputs, so scanning
    // and buffering carry on underneath.
    always_comb begin
        seg_n = '0;
        dp_n  = 1'b0;
        an_n  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                seg_n   = lane_seg[k];
                dp_n    = act_dp[k];
                an_n[k] = 1'b1;
            end
        end
        if (blank) begin
            seg_n = '0;
            dp_n  = 1'b0;
            an_n  = '0;
        end
    end

    // Output register. Polarity is applied here, so the reset values are
    // "off" in board polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg   <= {7{POL}};
            dp    <= POL;
            an    <= {DIGITS{POL}};
            frame <= 1'b0;
        end else begin
            seg   <= seg_n ^ {7{POL}};
            dp    <= dp_n ^ POL;
            an    <= an_n ^ {DIGITS{POL}};
            frame <= boundary;
        end
    end
endmodule
